// File: rtl/square_motion.sv
// Pong square motion: integrates px/s velocities into a position, bounces off walls and paddles, serves after a delay.
// Latency: position, hit_y/hit_valid and the miss state all update on the clk_0 edge that sees the step event.
// Backpressure: none; inputs are sampled every cycle and run=0 parks the square at centre in SERVE.
module square_motion #(
    parameter int CLK_HZ      = 25_175_000,
    parameter int H_RES       = 640,
    parameter int V_RES       = 480,
    parameter int SQ_SIZE     = 16,
    parameter int PDL_H       = 96,
    parameter int PDL_W       = 16,
    parameter int LPDL_X      = 16,
    parameter int RPDL_X      = 608,
    parameter int SERVE_DELAY = 25_175_000
) (
    input  logic       clk_0,
    input  logic       rst,
    input  logic       run,
    input  logic [8:0] sq_xvel,
    input  logic [8:0] sq_yvel,
    input  logic [8:0] lpdl_y,
    input  logic [8:0] rpdl_y,
    output logic [9:0] sq_x,
    output logic [8:0] sq_y,
    output logic [6:0] hit_y,
    output logic       hit_valid,
    output logic       sq_missed,
    output logic       miss_side
);
    localparam int ACC_W  = 25;
    localparam int ACC_SW = ACC_W + 1;
    localparam int CNT_W  = (SERVE_DELAY > 1) ? $clog2(SERVE_DELAY) : 1;

    localparam logic [9:0]       X_CTR    = 10'((H_RES - SQ_SIZE) / 2);
    localparam logic [8:0]       Y_CTR    = 9'((V_RES - SQ_SIZE) / 2);
    localparam logic [9:0]       X_MAX    = 10'(H_RES - SQ_SIZE);
    localparam logic [8:0]       Y_MAX    = 9'(V_RES - SQ_SIZE);
    localparam logic [9:0]       LHIT_X   = 10'(LPDL_X + PDL_W);
    localparam logic [9:0]       RHIT_X   = 10'(RPDL_X - SQ_SIZE);
    localparam logic [9:0]       SQ10     = 10'(SQ_SIZE);
    localparam logic [9:0]       PDL_H10  = 10'(PDL_H);
    localparam logic [9:0]       HALF_SQ  = 10'(SQ_SIZE / 2);
    localparam logic [9:0]       HALF_PDL = 10'(PDL_H / 2);
    localparam logic [ACC_W:0]   ACC_LIM  = ACC_SW'(CLK_HZ);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SERVE_DELAY - 1);

    typedef enum logic [1:0] {ST_SERVE, ST_MOVE, ST_MISS} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ACC_W-1:0] xacc_q, xacc_d, yacc_q, yacc_d;
    logic [9:0]       sq_x_q, sq_x_d;
    logic [8:0]       sq_y_q, sq_y_d;
    logic             x_dir_q, x_dir_d;   // 1 = right
    logic             y_dir_q, y_dir_d;   // 1 = down
    logic [6:0]       hit_y_q, hit_y_d;
    logic             hit_valid_q, hit_valid_d;
    logic             miss_side_q, miss_side_d;

    logic [ACC_W:0]   xsum, ysum;
    logic             x_step, y_step;
    logic [9:0]       sq_y10, pdl10, sq_ctr, pdl_ctr, diff;
    logic             ovl;

    // Sub-pixel integration and geometry against the paddle the square is heading toward
    always_comb begin
        xsum    = ACC_SW'(xacc_q) + ACC_SW'(sq_xvel);
        ysum    = ACC_SW'(yacc_q) + ACC_SW'(sq_yvel);
        x_step  = (xsum >= ACC_LIM);
        y_step  = (ysum >= ACC_LIM);
        sq_y10  = {1'b0, sq_y_q};
        pdl10   = {1'b0, (x_dir_q ? rpdl_y : lpdl_y)};
        ovl     = (sq_y10 + SQ10 > pdl10) && (sq_y10 < pdl10 + PDL_H10);
        sq_ctr  = sq_y10 + HALF_SQ;
        pdl_ctr = pdl10 + HALF_PDL;
        diff    = (sq_ctr >= pdl_ctr) ? (sq_ctr - pdl_ctr) : (pdl_ctr - sq_ctr);
    end

    // Next-state, position, direction and hit/miss bookkeeping
    always_comb begin
        state_d     = state_q;
        cnt_d       = '0;
        xacc_d      = '0;
        yacc_d      = '0;
        sq_x_d      = sq_x_q;
        sq_y_d      = sq_y_q;
        x_dir_d     = x_dir_q;
        y_dir_d     = y_dir_q;
        hit_y_d     = hit_y_q;
        hit_valid_d = 1'b0;
        miss_side_d = miss_side_q;
        if (!run) begin
            state_d = ST_SERVE;
            sq_x_d  = X_CTR;
            sq_y_d  = Y_CTR;
        end else begin
            case (state_q)
                ST_SERVE: begin
                    sq_x_d = X_CTR;
                    sq_y_d = Y_CTR;
                    if (cnt_q == CNT_LAST) state_d = ST_MOVE;
                    else                   cnt_d   = cnt_q + CNT_W'(1);
                end
                ST_MOVE: begin
                    xacc_d = x_step ? ACC_W'(xsum - ACC_LIM) : ACC_W'(xsum);
                    yacc_d = y_step ? ACC_W'(ysum - ACC_LIM) : ACC_W'(ysum);
                    if (y_step) begin
                        if (!y_dir_q && sq_y_q == '0)         y_dir_d = 1'b1;
                        else if (y_dir_q && sq_y_q == Y_MAX)  y_dir_d = 1'b0;
                        else sq_y_d = y_dir_q ? sq_y_q + 9'd1 : sq_y_q - 9'd1;
                    end
                    // A paddle hit judges overlap and offset on the pre-step sq_y
                    if (x_step) begin
                        if (sq_x_q == (x_dir_q ? RHIT_X : LHIT_X) && ovl) begin
                            x_dir_d     = !x_dir_q;
                            hit_valid_d = 1'b1;
                            hit_y_d     = 7'((diff > HALF_PDL) ? HALF_PDL : diff);
                            y_dir_d     = (sq_ctr >= pdl_ctr);
                        end else if (sq_x_q == (x_dir_q ? X_MAX : 10'd0)) begin
                            // Next serve heads toward the side that missed
                            state_d     = ST_MISS;
                            miss_side_d = x_dir_q;
                            sq_x_d      = X_CTR;
                            sq_y_d      = Y_CTR;
                        end else begin
                            sq_x_d = x_dir_q ? sq_x_q + 10'd1 : sq_x_q - 10'd1;
                        end
                    end
                end
                ST_MISS: begin
                    state_d = ST_SERVE;
                    sq_x_d  = X_CTR;
                    sq_y_d  = Y_CTR;
                end
                default: state_d = ST_SERVE;
            endcase
        end
    end

    // State register with synchronous reset to a centred, right/down square in SERVE
    always_ff @(posedge clk_0) begin
        if (rst) begin
            state_q     <= ST_SERVE;
            cnt_q       <= '0;
            xacc_q      <= '0;
            yacc_q      <= '0;
            sq_x_q      <= X_CTR;
            sq_y_q      <= Y_CTR;
            x_dir_q     <= 1'b1;
            y_dir_q     <= 1'b1;
            hit_y_q     <= '0;
            hit_valid_q <= 1'b0;
            miss_side_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            xacc_q      <= xacc_d;
            yacc_q      <= yacc_d;
            sq_x_q      <= sq_x_d;
            sq_y_q      <= sq_y_d;
            x_dir_q     <= x_dir_d;
            y_dir_q     <= y_dir_d;
            hit_y_q     <= hit_y_d;
            hit_valid_q <= hit_valid_d;
            miss_side_q <= miss_side_d;
        end
    end

    assign sq_x      = sq_x_q;
    assign sq_y      = sq_y_q;
    assign hit_y     = hit_y_q;
    assign hit_valid = hit_valid_q;
    assign sq_missed = (state_q == ST_MISS);
    assign miss_side = miss_side_q;
endmodule

// File: tb/tb_square_motion.sv
// Bench for square_motion with CLK_HZ=1000 and SERVE_DELAY=10 so motion is visible within a few thousand cycles.
// Latency: outputs are sampled 1 time unit after each rising edge of clk_0.
// Backpressure: none; stimulus is driven right after each sample.
module tb_square_motion;
    logic       clk_0 = 1'b0;
    logic       rst, run;
    logic [8:0] sq_xvel, sq_yvel, lpdl_y, rpdl_y;
    logic [9:0] sq_x;
    logic [8:0] sq_y;
    logic [6:0] hit_y;
    logic       hit_valid, sq_missed, miss_side;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_0 = ~clk_0;

    square_motion #(.CLK_HZ(1000), .SERVE_DELAY(10)) dut (
        .clk_0     (clk_0),
        .rst       (rst),
        .run       (run),
        .sq_xvel   (sq_xvel),
        .sq_yvel   (sq_yvel),
        .lpdl_y    (lpdl_y),
        .rpdl_y    (rpdl_y),
        .sq_x      (sq_x),
        .sq_y      (sq_y),
        .hit_y     (hit_y),
        .hit_valid (hit_valid),
        .sq_missed (sq_missed),
        .miss_side (miss_side)
    );

    typedef struct {
        logic       run;
        logic [8:0] xvel;
        logic [9:0] exp_x;
        logic [8:0] exp_y;
        logic       exp_hv;
        logic       exp_miss;
    } vec_t;

    vec_t vecs[21];

    task automatic tick();
        @(posedge clk_0);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    // sel: 0 = sq_x equals val, 1 = sq_y equals val, 2 = hit_valid, 3 = sq_missed
    task automatic wait_for(input string name, input int sel, input int val, input int max_cyc);
        bit seen = 1'b0;
        for (int i = 0; i < max_cyc && !seen; i++) begin
            tick();
            case (sel)
                0:       seen = (sq_x == val);
                1:       seen = (sq_y == val);
                2:       seen = hit_valid;
                default: seen = sq_missed;
            endcase
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL %s: got no event within %0d cycles, want event", name, max_cyc);
        end
    endtask

    // Called just after sq_y reached a wall; yvel=500 gives a step every 2 cycles
    task automatic check_bounce(input string name, input int wall_y, input int next_y);
        tick();
        tick();
        check({name, "_hold1"}, sq_y, wall_y);
        tick();
        check({name, "_hold2"}, sq_y, wall_y);
        tick();
        check({name, "_rebound"}, sq_y, next_y);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, want end of test");
        $fatal(1);
    end

    initial begin
        // Serve then constant 200 px/s: 10 SERVE cycles (row 0 has run=0), then a step every 5 cycles
        for (int i = 0; i < 21; i++) begin
            vecs[i].run      = (i != 0);
            vecs[i].xvel     = 9'd200;
            vecs[i].exp_x    = (i < 15) ? 10'd312 : (i < 20) ? 10'd313 : 10'd314;
            vecs[i].exp_y    = 9'd232;
            vecs[i].exp_hv   = 1'b0;
            vecs[i].exp_miss = 1'b0;
        end

        rst = 1'b1; run = 1'b0; sq_xvel = '0; sq_yvel = '0; lpdl_y = '0; rpdl_y = '0;
        tick();
        tick();
        check("rst_x", sq_x, 312);
        check("rst_y", sq_y, 232);
        check("rst_hit_y", hit_y, 0);
        check("rst_hv", hit_valid, 0);
        check("rst_miss", sq_missed, 0);
        check("rst_side", miss_side, 0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            run     = vecs[i].run;
            sq_xvel = vecs[i].xvel;
            tick();
            check($sformatf("vec%0d_x", i), sq_x, vecs[i].exp_x);
            check($sformatf("vec%0d_y", i), sq_y, vecs[i].exp_y);
            check($sformatf("vec%0d_hv", i), hit_valid, vecs[i].exp_hv);
            check($sformatf("vec%0d_miss", i), sq_missed, vecs[i].exp_miss);
        end

        // Right paddle hit at 592: centre 240 vs 248 -> hit_y 8, square turns left and up
        sq_xvel = 9'd500; rpdl_y = 9'd200; lpdl_y = 9'd0;
        wait_for("rhit1_wait", 2, 0, 1000);
        check("rhit1_x", sq_x, 592);
        check("rhit1_hit_y", hit_y, 8);
        sq_xvel = 9'd0; sq_yvel = 9'd500;
        tick();
        check("rhit1_pulse_len", hit_valid, 0);

        // Top wall: step at sq_y=0 flips direction without moving, next step gives 1
        wait_for("top_wait", 1, 0, 600);
        check_bounce("top", 0, 1);

        // Park at sq_y=240 and run into the left paddle at 200: centres equal -> hit_y 0
        wait_for("y240_wait", 1, 240, 600);
        sq_yvel = 9'd0; sq_xvel = 9'd500; lpdl_y = 9'd200;
        wait_for("lhit1_wait", 2, 0, 1500);
        check("lhit1_x", sq_x, 32);
        check("lhit1_hit_y", hit_y, 0);
        tick();
        check("lhit1_pulse_len", hit_valid, 0);
        tick();
        check("lhit1_rebound_x", sq_x, 33);

        // Right paddle at 220: centre 268 above 248 -> hit_y 20, y_dir up
        rpdl_y = 9'd220;
        wait_for("rhit2_wait", 2, 0, 1500);
        check("rhit2_x", sq_x, 592);
        check("rhit2_hit_y", hit_y, 20);
        sq_xvel = 9'd0; sq_yvel = 9'd500;

        // sq_y=150 against left paddle at 160: |158-208|=50 clamps to 48, y_dir up
        wait_for("y150_wait", 1, 150, 400);
        sq_yvel = 9'd0; sq_xvel = 9'd500; lpdl_y = 9'd160;
        wait_for("lhit2_wait", 2, 0, 1500);
        check("lhit2_x", sq_x, 32);
        check("lhit2_hit_y", hit_y, 48);
        sq_xvel = 9'd0; sq_yvel = 9'd500;
        tick();
        tick();
        check("lhit2_ydir_up", sq_y, 149);

        // Bottom wall at V_RES-SQ_SIZE = 464
        wait_for("bottom_wait", 1, 464, 1500);
        check_bounce("bottom", 464, 463);

        // Miss on the right: sq_y=400 clears the paddle at rpdl_y=0
        wait_for("y400_wait", 1, 400, 200);
        sq_yvel = 9'd0; sq_xvel = 9'd500; rpdl_y = 9'd0;
        wait_for("miss_wait", 3, 0, 1500);
        check("miss_x", sq_x, 312);
        check("miss_y", sq_y, 232);
        check("miss_side", miss_side, 1);
        check("miss_hv", hit_valid, 0);
        tick();
        check("miss_pulse_len", sq_missed, 0);
        for (int i = 2; i <= 12; i++) begin
            tick();
            check($sformatf("serve_hold%0d", i), sq_x, 312);
        end
        tick();
        check("serve_right_x", sq_x, 313);

        // run dropped mid-rally parks the square; hit_y and miss_side are kept
        run = 1'b0;
        tick();
        check("stop_x", sq_x, 312);
        check("stop_y", sq_y, 232);
        check("stop_hv", hit_valid, 0);
        check("stop_miss", sq_missed, 0);
        check("stop_side_held", miss_side, 1);
        run = 1'b1;
        for (int i = 0; i < 14; i++) tick();
        check("rerun_x", sq_x, 314);

        // Reset mid-MOVE restores every output on the next edge
        rst = 1'b1;
        tick();
        check("rst2_x", sq_x, 312);
        check("rst2_y", sq_y, 232);
        check("rst2_hit_y", hit_y, 0);
        check("rst2_side", miss_side, 0);
        check("rst2_hv", hit_valid, 0);
        check("rst2_miss", sq_missed, 0);
        rst = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/square_motion.md
Name: square_motion

Overview:
- Moves the pong square: integrates sq_xvel/sq_yvel (pixels/second) into an on-screen position.
- Bounces the square off the top and bottom walls and off both paddles.
- Measures the paddle hit offset hit_y, flags out-of-bounds misses and serves after a delay.
- Sits between the paddle controllers and the velocity mapper. It consumes the velocities and produces hit_y and sq_missed; the renderer reads sq_x/sq_y.

Parameters:
- CLK_HZ, 25_175_000, clock frequency; the velocity integration divisor.
- H_RES, 640, visible width in pixels.
- V_RES, 480, visible height in pixels.
- SQ_SIZE, 16, square side in pixels.
- PDL_H, 96, paddle height.
- PDL_W, 16, paddle width.
- LPDL_X, 16, left paddle left-edge x.
- RPDL_X, 608, right paddle left-edge x.
- SERVE_DELAY, 25_175_000, cycles the square is held at centre before each serve.

Ports:
- clk_0  in  1  25.175 MHz clock.
- rst  in  1  synchronous reset, active-high.
- run  in  1  high while a rally may be played (low during startup menu or game over).
- sq_xvel  in  9  horizontal speed, px/s.
- sq_yvel  in  9  vertical speed, px/s.
- lpdl_y  in  9  left paddle top y.
- rpdl_y  in  9  right paddle top y.
- sq_x  out  10  square left-edge x.
- sq_y  out  9  square top y.
- hit_y  out  7  |square centre y − paddle centre y| at last hit, clamped to PDL_H/2.
- hit_valid  out  1  one-cycle pulse on each paddle hit.
- sq_missed  out  1  one-cycle pulse when the square leaves the field.
- miss_side  out  1  side of last miss: 0 = left, 1 = right. Held until the next miss.

Behaviour:
- Reset (rst=1 at clk_0 edge):
  - Position: sq_x=(H_RES−SQ_SIZE)/2=312, sq_y=(V_RES−SQ_SIZE)/2=232.
  - Directions: x_dir=right, y_dir=down.
  - Accumulators: both 25-bit accumulators = 0.
  - State and counter: state=SERVE, serve counter=0.
  - Outputs: hit_y=0, hit_valid=0, sq_missed=0, miss_side=0.
  - Reset mid-rally takes effect on the next edge; no pulses are emitted.
- States:
  - SERVE: square held at centre, accumulators cleared. Counter increments while run=1. When counter==SERVE_DELAY−1, go to MOVE and clear the counter.
  - MOVE: integrate position and detect collisions.
  - MISS: lasts exactly 1 cycle. sq_missed=1; position returns to centre; x_dir set toward the side that missed; y_dir unchanged. Then go to SERVE.
- run=0 in any state: next state SERVE, counter cleared, position centre, no pulses.
- Integration (MOVE, per axis, independent):
  - acc_n = acc + vel.
  - If acc_n ≥ CLK_HZ: acc ← acc_n − CLK_HZ and a one-pixel step event occurs this cycle. Otherwise acc ← acc_n.
  - Velocities are sampled each cycle. vel=0 means no motion on that axis. At most one step per axis per cycle.
- Y step event:
  - Moving up with sq_y==0: y_dir←down, no move.
  - Moving down with sq_y==V_RES−SQ_SIZE: y_dir←up, no move.
  - Otherwise sq_y ± 1.
- X step event, moving left:
  - Paddle contact: sq_x==LPDL_X+PDL_W and vertical overlap (sq_y+SQ_SIZE > lpdl_y and sq_y < lpdl_y+PDL_H).
    - x_dir←right, no move, hit_valid=1.
    - hit_y ← min(|(sq_y+SQ_SIZE/2) − (lpdl_y+PDL_H/2)|, PDL_H/2).
    - y_dir ← up if square centre < paddle centre, else down.
  - No overlap and sq_x==0: go to MISS with miss_side=0.
  - Otherwise sq_x−1.
- X step event, moving right: mirror of the left case.
  - Contact at sq_x+SQ_SIZE==RPDL_X with the overlap test against rpdl_y.
  - Miss at sq_x==H_RES−SQ_SIZE with miss_side=1.
- Simultaneous X and Y steps in the same cycle are both applied. A paddle hit uses the pre-step sq_y.
- hit_y is registered on the hit cycle and held; the velocity mapper updates from it on the following cycle.
- hit_valid and sq_missed are never high in the same cycle.

Test Plan:
- Reset then run=1, CLK_HZ=1000, SERVE_DELAY=10, sq_xvel=200, sq_yvel=0 -> square held at (312,232) for 10 cycles; sq_x increments every 5 cycles thereafter.
- sq_yvel=250, sq_y driven to 0 moving up -> next y step flips y_dir with sq_y staying 0; following step gives sq_y=1.
- Square moving left at sq_x=32, lpdl_y=200, sq_y=240 -> hit_valid 1 cycle; hit_y=|248−248|=0; x_dir right; next x step gives sq_x=33.
- Same setup with sq_y=150 -> hit_y=|158−248| clamped to 48; y_dir=up.
- Square moving right, rpdl_y=0, sq_y=400, reaching sq_x=624 -> sq_missed 1 cycle, miss_side=1, position (312,232), SERVE_DELAY cycles elapse before motion toward the right.
- run dropped mid-rally, then rst pulsed mid-MOVE -> position returns to centre next edge, no hit_valid/sq_missed pulses, outputs at reset values.
